// File: rtl/tx_gearbox_6664_pkg.sv
// ============================================================================
// Module : tx_gearbox_6664_pkg
// Brief  : Shared PHY widths, sync-header codes and gearbox sequence limits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tx_gearbox_6664_pkg;

    localparam int BLOCK_W     = 66;
    localparam int WORD_W      = 64;
    localparam int GB_SEQ_LAST = 32;
    localparam int SEQ_W       = 6;
    localparam int CAT_W       = 2 * WORD_W;

    localparam logic [1:0]       HDR_DATA = 2'b01;
    localparam logic [1:0]       HDR_CTRL = 2'b10;
    localparam logic [SEQ_W-1:0] SEQ_LAST = SEQ_W'(GB_SEQ_LAST);

    typedef logic [SEQ_W-1:0] seq_t;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == HDR_DATA) || (hdr == HDR_CTRL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_gearbox_6664.sv
// ============================================================================
// Module : tx_gearbox_6664
// Brief  : 66b->64b transmit gearbox; one pause cycle every 33 cycles.
//          Optional sticky header check: TX_GEARBOX_HDR_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tx_gearbox_6664
    import tx_gearbox_6664_pkg::*;
(
    input  logic              i_txc,
    input  logic              i_reset_n,
    input  logic              i_init_done,
    input  logic [WORD_W-1:0] i_txd,
    input  logic [1:0]        i_tx_header,
    output logic [WORD_W-1:0] o_txd,
    output logic              o_tx_pause
`ifdef TX_GEARBOX_HDR_CHECK_EN
    ,
    output logic              o_hdr_err
`endif
);

    seq_t              r_seq;
    logic [WORD_W-1:0] r_res;
    logic [WORD_W-1:0] r_txd;
    logic              w_pause;
    logic [CAT_W-1:0]  w_cat;

    // Residue bits above 2*seq are always zero, so a plain OR merges them.
    always_comb begin
        w_pause = (r_seq == SEQ_LAST);
        w_cat   = ({{(CAT_W-BLOCK_W){1'b0}}, i_txd, i_tx_header} << {r_seq, 1'b0})
                | {{(CAT_W-WORD_W){1'b0}}, r_res};
    end

    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_seq <= '0;
            r_res <= '0;
            r_txd <= '0;
        end else if (!i_init_done) begin
            r_seq <= '0;
            r_res <= '0;
            r_txd <= '0;
        end else if (w_pause) begin
            r_txd <= r_res;
            r_res <= '0;
            r_seq <= '0;
        end else begin
            r_txd <= w_cat[WORD_W-1:0];
            r_res <= w_cat[CAT_W-1:WORD_W];
            r_seq <= r_seq + 1'b1;
        end
    end

`ifdef TX_GEARBOX_HDR_CHECK_EN
    logic r_hdr_err;

    always_ff @(posedge i_txc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hdr_err <= 1'b0;
        end else if (i_init_done && !w_pause && !hdr_valid(i_tx_header)) begin
            r_hdr_err <= 1'b1;
        end
    end

    assign o_hdr_err = r_hdr_err;
`endif

    assign o_txd      = r_txd;
    assign o_tx_pause = w_pause;

endmodule

`default_nettype wire

// File: tb/tb_tx_gearbox_6664.sv
// ============================================================================
// Module : tb_tx_gearbox_6664
// Brief  : Randomized bench; the model treats the gearbox as a bit FIFO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tx_gearbox_6664;

    logic        clk;
    logic        rst_n;
    logic        init_done;
    logic [63:0] txd;
    logic [1:0]  hdr;
    logic [63:0] o_txd;
    logic        o_tx_pause;
`ifdef TX_GEARBOX_HDR_CHECK_EN
    logic        o_hdr_err;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    tx_gearbox_6664 dut (
        .i_txc       (clk),
        .i_reset_n   (rst_n),
        .i_init_done (init_done),
        .i_txd       (txd),
        .i_tx_header (hdr),
        .o_txd       (o_txd),
        .o_tx_pause  (o_tx_pause)
`ifdef TX_GEARBOX_HDR_CHECK_EN
        ,
        .o_hdr_err   (o_hdr_err)
`endif
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: input bits queued LSB-first, every active cycle emits 64 of them;
    // a cycle is a pause when 32 blocks have gone in since the period began.
    bit          mq[$];
    int          m_idx = 0;
    logic [63:0] exp_word = '0;
    logic        exp_pause = 0;
    logic        exp_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_idx     = 0;
            exp_word  = '0;
            exp_pause = 0;
            exp_err   = 0;
        end else if (!init_done) begin
            mq.delete();
            m_idx    = 0;
            exp_word = '0;
        end else begin
            if (m_idx == 32) begin
                m_idx = 0;
            end else begin
                logic [65:0] blk;
                blk = {txd, hdr};
                for (int b = 0; b < 66; b++) mq.push_back(blk[b]);
                if (hdr == 2'b00 || hdr == 2'b11) exp_err = 1;
                m_idx++;
            end
            for (int b = 0; b < 64; b++) exp_word[b] = mq.pop_front();
        end
        exp_pause = (m_idx == 32);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (o_txd !== exp_word) begin
                errors++;
                $display("FAIL txd_stream: got %h expected %h", o_txd, exp_word);
            end
            checks++;
            if (o_tx_pause !== exp_pause) begin
                errors++;
                $display("FAIL pause_cadence: got %b expected %b", o_tx_pause, exp_pause);
            end
`ifdef TX_GEARBOX_HDR_CHECK_EN
            checks++;
            if (o_hdr_err !== exp_err) begin
                errors++;
                $display("FAIL hdr_err_model: got %b expected %b", o_hdr_err, exp_err);
            end
`endif
        end
    end

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic rand_blk();
        txd = {$urandom, $urandom};
        hdr = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endtask

    // Random traffic honouring the re-present-after-pause contract.
    bit hold = 0;
    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            if (!hold) rand_blk();
            hold = (m_idx == 32);
            next_cycle();
        end
    endtask

    task automatic run_to_idx(input int target);
        int guard = 0;
        while (m_idx != target && guard < 100) begin
            run_random(1);
            guard++;
        end
        checks++;
        if (m_idx != target) begin
            errors++;
            $display("FAIL run_to_idx: got %0d expected %0d", m_idx, target);
        end
    endtask

    // From the first consume edge, pause must show exactly after edge 32.
    task automatic check_first_pause(input string tag);
        run_random(30);
        check1({tag, "_no_pause_31"}, o_tx_pause, 1'b0);
        run_random(1);
        check1({tag, "_pause_32"}, o_tx_pause, 1'b1);
        run_random(1);
        check1({tag, "_pause_end_33"}, o_tx_pause, 1'b0);
    endtask

    initial begin
        rst_n     = 0;
        init_done = 0;
        txd       = '0;
        hdr       = 2'b01;
        #2;
        chk_on = 1;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check64("reset_txd", o_txd, 64'h0);
            check1("reset_pause", o_tx_pause, 1'b0);
        end
`ifdef TX_GEARBOX_HDR_CHECK_EN
        check1("reset_hdr_err", o_hdr_err, 1'b0);
`endif

        rst_n = 1;
        rand_blk();
        for (int i = 0; i < 3; i++) next_cycle();
        check64("idle_txd", o_txd, 64'h0);

        init_done = 1;
        hdr = 2'b01;
        txd = 64'hFFFF_FFFF_FFFF_FFFF;
        next_cycle();
        check64("first_word", o_txd, 64'hFFFF_FFFF_FFFF_FFFD);
        check_first_pause("start");
        run_random(140);

        run_to_idx(17);
        rst_n = 0;
        #1;
        check64("midreset_txd", o_txd, 64'h0);
        check1("midreset_pause", o_tx_pause, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) next_cycle();
        rst_n = 1;
        rand_blk();
        hold = 0;
        next_cycle();
        check_first_pause("after_reset");
        run_random(40);

        run_to_idx(10);
        init_done = 0;
        for (int i = 0; i < 3; i++) begin
            rand_blk();
            next_cycle();
        end
        check64("init_low_txd", o_txd, 64'h0);
        init_done = 1;
        rand_blk();
        hold = 0;
        next_cycle();
        check_first_pause("after_init");
        run_random(70);

`ifdef TX_GEARBOX_HDR_CHECK_EN
        run_to_idx(32);
        txd = {$urandom, $urandom};
        hdr = 2'b11;
        next_cycle();
        hdr = 2'b01;
        next_cycle();
        check1("hdr_pause_ignored", o_hdr_err, 1'b0);
        hold = 0;
        run_to_idx(5);
        hdr = 2'b00;
        next_cycle();
        check1("hdr_err_set", o_hdr_err, 1'b1);
        run_random(40);
        check1("hdr_err_sticky", o_hdr_err, 1'b1);
        rst_n = 0;
        #1;
        check1("hdr_err_reset", o_hdr_err, 1'b0);
        #1;
        next_cycle();
        rst_n = 1;
        run_random(5);
`endif

        chk_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
